// File: rtl/mon_fifo_ctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mon_fifo_ctl_if : push/pop handshake and block-RAM port bundle        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface mon_fifo_ctl_if #(
  parameter int AW = 11,
  parameter int DW = 18
);
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          afull;
  logic          overflow;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  modport slave (
    input  clr, wr_en, wr_data, rd_ready, ram_do,
    output full, afull, overflow, rd_valid, rd_data, count,
           ram_ce, ram_we, ram_addr, ram_di
  );

  modport master (
    output clr, wr_en, wr_data, rd_ready, ram_do,
    input  full, afull, overflow, rd_valid, rd_data, count,
           ram_ce, ram_we, ram_addr, ram_di
  );
endinterface
`default_nettype wire

// File: rtl/mon_fifo_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mon_fifo_ctl : single-port-RAM FIFO controller, writes win the port   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module mon_fifo_ctl #(
  parameter int AW       = 11,
  parameter int DW       = 18,
  parameter int AFULL_TH = 1792
) (
  input  logic           clk,
  input  logic           rst,
  mon_fifo_ctl_if.slave  bus
);
  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AFULL = (AW+1)'(AFULL_TH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [DW-1:0] whb_q, whb_d, ob0_q, ob0_d, ob1_q, ob1_d;
  logic          whb_v_q, whb_v_d, inflight_q, inflight_d;
  logic          full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;

  logic          push, pop, rd_issue;
  logic [AW:0]   ram_words;
  logic [2:0]    occ_after;

  always_comb begin
    push      = bus.wr_en & ~full_q;
    pop       = (ob_cnt_q != 2'd0) & bus.rd_ready;
    ram_words = wr_ptr_q - rd_ptr_q;
    // queue occupancy once this cycle's return and pop have settled
    occ_after = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue  = ~whb_v_q & (ram_words != '0) & (occ_after < 3'd2);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    whb_d      = whb_q;
    whb_v_d    = whb_v_q;
    inflight_d = inflight_q;
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    ob_cnt_d   = ob_cnt_q;
    full_d     = full_q;
    afull_d    = afull_q;
    ovf_d      = ovf_q | (bus.wr_en & full_q);

    whb_d   = push ? bus.wr_data : whb_q;
    whb_v_d = push;
    if (whb_v_q)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_issue) rd_ptr_d = rd_ptr_q + 1'b1;
    inflight_d = rd_issue;

    ob_cnt_d = occ_after[1:0];
    unique case ({inflight_q, pop})
      2'b10: begin
        if (ob_cnt_q == 2'd0) ob0_d = bus.ram_do;
        else                  ob1_d = bus.ram_do;
      end
      2'b01: ob0_d = ob1_q;
      2'b11: begin
        if (ob_cnt_q == 2'd1) begin
          ob0_d = bus.ram_do;
        end else begin
          ob0_d = ob1_q;
          ob1_d = bus.ram_do;
        end
      end
      default: ;
    endcase

    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    full_d  = (count_d >= C_DEPTH);
    afull_d = (count_d >= C_AFULL);

    // flush keeps the sticky overflow so the loss stays visible
    if (bus.clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      whb_d      = whb_q;
      whb_v_d    = 1'b0;
      inflight_d = 1'b0;
      ob0_d      = '0;
      ob1_d      = '0;
      ob_cnt_d   = 2'd0;
      full_d     = 1'b0;
      afull_d    = 1'b0;
      ovf_d      = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      whb_q      <= '0;
      whb_v_q    <= 1'b0;
      inflight_q <= 1'b0;
      ob0_q      <= '0;
      ob1_q      <= '0;
      ob_cnt_q   <= 2'd0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      whb_q      <= whb_d;
      whb_v_q    <= whb_v_d;
      inflight_q <= inflight_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
      ob_cnt_q   <= ob_cnt_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.full     = full_q;
  assign bus.afull    = afull_q;
  assign bus.overflow = ovf_q;
  assign bus.rd_valid = (ob_cnt_q != 2'd0);
  assign bus.rd_data  = ob0_q;
  assign bus.count    = count_q;
  assign bus.ram_ce   = whb_v_q | rd_issue;
  assign bus.ram_we   = whb_v_q;
  assign bus.ram_addr = whb_v_q  ? wr_ptr_q[AW-1:0] :
                        rd_issue ? rd_ptr_q[AW-1:0] : '0;
  assign bus.ram_di   = whb_v_q ? whb_q : '0;
endmodule
`default_nettype wire

// File: tb/tb_mon_fifo_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mon_fifo_ctl : directed bench with RAM model and FIFO scoreboard   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_mon_fifo_ctl;
  localparam int AW = 11;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:2047];

  always #5 clk = ~clk;

  mon_fifo_ctl_if #(.AW(AW), .DW(DW)) bus ();
  mon_fifo_ctl #(.AW(AW), .DW(DW), .AFULL_TH(1792)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // synchronous single-port RAM: read data appears after the sampling edge
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
      else            bus.ram_do <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one clock of normal operation with scoreboard update and flag checks
  task automatic step();
    logic          stalled;
    logic [DW-1:0] held;
    logic [DW-1:0] want;
    if (bus.rd_valid && bus.rd_ready) begin
      n_pop++;
      if (exp_q.size() == 0) chk("pop_empty", 32'd1, 32'd0);
      else begin
        want = exp_q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(want));
      end
    end
    if (bus.wr_en && !bus.full) exp_q.push_back(bus.wr_data);
    stalled = bus.rd_valid && !bus.rd_ready;
    held    = bus.rd_data;
    tick();
    if (stalled) begin
      chk("hold_valid", 32'(bus.rd_valid), 32'd1);
      chk("hold_data", 32'(bus.rd_data), 32'(held));
    end
    chk("count", 32'(bus.count), 32'(exp_q.size()));
    chk("full", 32'(bus.full), 32'(exp_q.size() >= 2048));
    chk("afull", 32'(bus.afull), 32'(exp_q.size() >= 1792));
  endtask

  initial begin
    int gaps;
    int started;
    int pushed;
    int pop0;

    bus.clr = 1'b0; bus.wr_en = 1'b1; bus.wr_data = 18'h3FFFF; bus.rd_ready = 1'b0;

    // reset held two cycles with a push request pending
    tick(); tick();
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_afull", 32'(bus.afull), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_ram_ce", 32'(bus.ram_ce), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    rst = 1'b0; bus.wr_en = 1'b0;
    tick();
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_count2", 32'(bus.count), 32'd0);

    // single word latency
    bus.wr_en = 1'b1; bus.wr_data = 18'h2A5A5;
    step();
    bus.wr_en = 1'b0;
    chk("e0_we", 32'(bus.ram_we), 32'd1);
    chk("e0_addr", 32'(bus.ram_addr), 32'd0);
    chk("e0_di", 32'(bus.ram_di), 32'h2A5A5);
    step();
    chk("e1_ce", 32'(bus.ram_ce), 32'd1);
    chk("e1_we", 32'(bus.ram_we), 32'd0);
    chk("e1_addr", 32'(bus.ram_addr), 32'd0);
    chk("e1_valid", 32'(bus.rd_valid), 32'd0);
    step();
    chk("e2_valid", 32'(bus.rd_valid), 32'd0);
    chk("e2_ce", 32'(bus.ram_ce), 32'd0);
    step();
    chk("e3_valid", 32'(bus.rd_valid), 32'd1);
    chk("e3_data", 32'(bus.rd_data), 32'h2A5A5);
    bus.rd_ready = 1'b1;
    step();
    chk("single_drained", 32'(bus.rd_valid), 32'd0);
    bus.rd_ready = 1'b0;

    // fill to capacity; write pointer starts at 1 so address wraps 2047 -> 0
    for (int i = 0; i < 2048; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 18'(i);
      step();
      chk("fill_addr", 32'(bus.ram_addr), 32'((i + 1) % 2048));
      chk("fill_we", 32'(bus.ram_we), 32'd1);
    end
    bus.wr_data = 18'h3ABCD;
    step();
    bus.wr_en = 1'b0;
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd2048);

    // drain: in order, one word per cycle once started
    bus.rd_ready = 1'b1;
    gaps = 0; started = 0;
    for (int c = 0; c < 2300 && exp_q.size() > 0; c++) begin
      if (bus.rd_valid) started = 1;
      step();
      if (started != 0 && !bus.rd_valid && exp_q.size() > 0) gaps++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_gaps", 32'(gaps), 32'd0);

    // preload 1000, pop 1000, then stream 3000 across the pointer wrap
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 18'h10000 | 18'(i);
      step();
    end
    bus.wr_en = 1'b0; bus.rd_ready = 1'b1;
    for (int c = 0; c < 1200 && exp_q.size() > 0; c++) step();
    chk("preload_drained", 32'(exp_q.size()), 32'd0);
    pushed = 0;
    for (int c = 0; c < 8000 && (pushed < 3000 || exp_q.size() > 0); c++) begin
      bus.wr_en = (pushed < 3000) && (c % 2 == 0);
      bus.wr_data = 18'h20000 | 18'(pushed);
      if (bus.wr_en && !bus.full) pushed++;
      step();
    end
    bus.wr_en = 1'b0;
    chk("stream_pushed", 32'(pushed), 32'd3000);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // random backpressure over 500 words
    pushed = 0; pop0 = n_pop;
    for (int c = 0; c < 6000 && (pushed < 500 || exp_q.size() > 0); c++) begin
      bus.rd_ready = 1'($urandom_range(0, 1));
      bus.wr_en = (pushed < 500) && ($urandom_range(0, 3) != 0);
      bus.wr_data = 18'($urandom);
      if (bus.wr_en && !bus.full) pushed++;
      step();
    end
    bus.wr_en = 1'b0;
    chk("bp_pops", 32'(n_pop - pop0), 32'd500);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // clear while a write is pending and a read is in flight
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 36; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 18'h00100 + 18'(i);
      step();
    end
    bus.wr_en = 1'b0;
    step();
    chk("pre_clr_rd_issue", 32'({bus.ram_ce, bus.ram_we}), 32'b10);
    bus.wr_en = 1'b1; bus.wr_data = 18'h00999;
    step();
    bus.wr_en = 1'b0;
    chk("pre_clr_count", 32'(bus.count), 32'd37);
    chk("pre_clr_whb", 32'(bus.ram_we), 32'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    exp_q.delete();
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("clr_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("clr_ovf_kept", 32'(bus.overflow), 32'd1);
    chk("clr_full", 32'(bus.full), 32'd0);
    bus.wr_en = 1'b1; bus.wr_data = 18'h3C3C3;
    step();
    bus.wr_en = 1'b0; bus.rd_ready = 1'b1;
    pop0 = n_pop;
    for (int c = 0; c < 20 && n_pop == pop0; c++) step();
    chk("clr_first_word_popped", 32'(n_pop - pop0), 32'd1);
    chk("clr_final_count", 32'(bus.count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mon_fifo_ctl.md
Name: mon_fifo_ctl

Overview:
- Single-clock FIFO controller for the monitor trace path.
- Drives a single-port 2K x 18 block RAM: it issues the RAM enable, write-enable, address and write data, and consumes the RAM read data.
- One RAM port is time-shared between writes and read prefetch. Writes have priority.
- The read side delivers data in order through a valid/ready interface backed by a 2-entry output queue.

Parameters:
- AW, 11, RAM address width; RAM depth is DEPTH = 2**AW = 2048.
- DW, 18, data width.
- AFULL_TH, 1792, almost-full threshold on total occupancy.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- clr, in, 1, synchronous flush, active high.
- wr_en, in, 1, push request.
- wr_data, in, DW, push data.
- full, out, 1, registered; push is dropped while high.
- afull, out, 1, registered; high when count >= AFULL_TH.
- overflow, out, 1, sticky; set when wr_en arrives while full.
- rd_valid, out, 1, head-of-queue data valid.
- rd_ready, in, 1, consumer accepts the head word.
- rd_data, out, DW, head word.
- count, out, AW+1, total words held.
- ram_ce, out, 1, RAM chip enable, active high.
- ram_we, out, 1, RAM write enable, active high.
- ram_addr, out, AW, RAM address.
- ram_di, out, DW, RAM write data.
- ram_do, in, DW, RAM read data; valid in the cycle after the edge that sampled a read.

Behaviour:
- Reset/clear values: rst or clr forces all of the following to 0 on the next edge: wr_ptr, rd_ptr, write-hold register (whb_v), inflight flag, output queue (ob_cnt), count, full, afull, rd_valid, rd_data.
  - rst also clears overflow; clr does not.
  - rst has priority over clr; clr has priority over all other activity.
- RAM port signals are combinational from registered state, so they are all 0 during and after reset.
- Push:
  - wr_en with full = 0 loads whb <= wr_data and sets whb_v.
  - wr_en with full = 1 drops the word and sets overflow.
  - full is the registered flag. A pop in the same cycle does not admit a push.
- Port arbitration, per cycle:
  - If whb_v: ram_ce = 1, ram_we = 1, ram_addr = wr_ptr, ram_di = whb. At the edge, wr_ptr += 1 (mod DEPTH) and whb_v clears unless a new push reloads it.
  - Else, if ram_words > 0 and (ob_cnt + inflight - pop) < 2: issue a read with ram_ce = 1, ram_we = 0, ram_addr = rd_ptr. At the edge, rd_ptr += 1 and inflight <= 1.
  - Otherwise ram_ce = 0. ram_di = 0 whenever ram_we = 0.
- ram_words is (wr_ptr - rd_ptr) mod DEPTH, extended with a wrap bit so that 0 and DEPTH are distinguishable.
- Sustained back-to-back writes starve reads. Reads resume in the first cycle with whb_v = 0.
- Read return: when inflight = 1, ram_do is pushed into the output queue at the next edge and inflight clears, unless a new read is issued.
- Output queue:
  - 2 entries; rd_data is the head; rd_valid = (ob_cnt > 0).
  - pop = rd_valid & rd_ready.
  - A simultaneous pop and load in the same cycle keeps order.
  - rd_data is held stable while rd_valid & ~rd_ready.
- count: +1 on an accepted push, -1 on pop, unchanged when both occur.
  - count spans whb, RAM, inflight and the output queue.
  - full <= (next count >= DEPTH); afull <= (next count >= AFULL_TH).
- Capacity is DEPTH words.
- Latency: a push sampled at edge E0 writes the RAM at E1, issues its read at E2, and appears with rd_valid high after E3, provided the FIFO was empty and rd_ready had no effect.
- Throughput: 1 word/cycle on read when no writes are pending; 1 word/cycle on write always.
- Pointer wrap: 2047 -> 0 with no gap or duplicate.

Test Plan:
- Reset: hold rst 2 cycles with wr_en = 1 -> full = afull = overflow = rd_valid = ram_ce = 0, count = 0; rd_data = 0 after release.
- Single word: push 18'h2A5A5 at E0 with rd_ready = 0 -> ram_we = 1 and ram_addr = 0 in cycle E0-E1; read at E2 with ram_addr = 0; rd_valid = 1 and rd_data = 18'h2A5A5 after E3; count = 1 until the pop.
- Fill: 2048 pushes of incrementing data with rd_ready = 0 -> afull asserts when count reaches 1792; full asserts at 2048; push 2049 is dropped and overflow = 1; drain returns 0..2047 in order, with full clearing after the first pop.
- Wrap/throughput: preload 1000 words, pop 1000, then stream 3000 words with rd_ready = 1 -> output order is exact across the pointer wrap; while writing, rd_valid gaps occur only during write cycles.
- Backpressure: rd_ready toggles on a pseudo-random pattern during a 500-word transfer -> no loss or duplication, and rd_data is stable while stalled.
- clr mid-stream: clr asserted with count = 37, whb_v = 1 and inflight = 1 -> next cycle count = 0 and rd_valid = 0, overflow is preserved, and a subsequent push is returned as the first word.
